// File: rtl/fft_reorder.sv
// fft_reorder: natural-order reorder buffer at the tail of the radix-2 pipelined FFT.
// Ping-pong RAM: one bank is filled from the bit-reversed input stream while the
// other bank is read out in natural order, sustaining continuous throughput.
// Ports:
//   clk, areset            clock, asynchronous active-low reset
//   en_in, cnt_in          input valid and bit-reversed sample index
//   xin_re, xin_im         input sample (signed)
//   en_out, cnt_out        output valid and natural-order index
//   yout_re, yout_im       output sample (signed)
//   ovf                    sticky: a frame was dropped because no bank was free
//   last_out               only with FFT_REORDER_LAST_EN defined: marks cnt_out = 2^N-1
module fft_reorder #(
    parameter int width = 16,
    parameter int N     = 9
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    en_in,
    input  logic [N-1:0]            cnt_in,
    input  logic signed [width-1:0] xin_re,
    input  logic signed [width-1:0] xin_im,
    output logic                    en_out,
    output logic [N-1:0]            cnt_out,
    output logic signed [width-1:0] yout_re,
    output logic signed [width-1:0] yout_im,
    output logic                    ovf
`ifdef FFT_REORDER_LAST_EN
    ,
    output logic                    last_out
`endif
);
    localparam int DEPTH = 2 ** N;
    localparam logic [N-1:0] LAST = '1;

    typedef enum logic {IDLE, READ} state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_full, w_full_nxt, w_set, w_clr;
    logic               r_wr_bank, r_rd_bank, w_rd_bank_nxt;
    logic               r_drop, w_drop, w_busy, w_start, w_end;
    logic               w_rd_en, w_rd_last, r_rd_vld;
    logic [N-1:0]       r_rd_cnt, w_rd_cnt_nxt, r_rd_idx;
    logic [2*width-1:0] r_mem [2*DEPTH];
    logic [2*width-1:0] r_rdata;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = a[N-1-i];
        return b;
    endfunction

    assign w_start   = en_in && cnt_in == '0;
    assign w_end     = en_in && cnt_in == LAST;
    assign w_rd_en   = r_state == READ;
    assign w_rd_last = w_rd_en && r_rd_cnt == LAST;
    // A bank whose final word is being read this cycle is already free for a new frame.
    assign w_busy    = r_full[r_wr_bank] && !(w_rd_last && r_rd_bank == r_wr_bank);
    // The drop decision taken at frame start already governs that first sample.
    assign w_drop    = w_start ? w_busy : r_drop;
    assign w_set     = (w_end && !w_drop) ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr     = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_full_nxt = (r_full & ~w_clr) | w_set;

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_cnt_nxt  = r_rd_cnt;
        w_rd_bank_nxt = r_rd_bank;
        if (r_state == IDLE) begin
            if (r_full[r_rd_bank]) begin
                w_state_nxt  = READ;
                w_rd_cnt_nxt = '0;
            end
        end else begin
            w_rd_cnt_nxt = r_rd_cnt + 1'b1;
            if (w_rd_last) begin
                w_rd_bank_nxt = ~r_rd_bank;
                w_state_nxt   = w_full_nxt[~r_rd_bank] ? READ : IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en_in && !w_drop) r_mem[{r_wr_bank, bitrev(cnt_in)}] <= {xin_re, xin_im};
        if (w_rd_en) r_rdata <= r_mem[{r_rd_bank, r_rd_cnt}];
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state   <= IDLE;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
            r_wr_bank <= 1'b0;
            r_full    <= 2'b00;
            r_drop    <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_idx  <= '0;
            ovf       <= 1'b0;
            en_out    <= 1'b0;
            cnt_out   <= '0;
            yout_re   <= '0;
            yout_im   <= '0;
`ifdef FFT_REORDER_LAST_EN
            last_out  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_rd_cnt  <= w_rd_cnt_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_wr_bank <= r_wr_bank ^ (w_end && !w_drop);
            r_full    <= w_full_nxt;
            r_drop    <= w_end ? 1'b0 : w_drop;
            ovf       <= ovf | (w_end && w_drop);
            r_rd_vld  <= w_rd_en;
            if (w_rd_en) r_rd_idx <= r_rd_cnt;
            en_out    <= r_rd_vld;
            if (r_rd_vld) {cnt_out, yout_re, yout_im} <= {r_rd_idx, r_rdata};
`ifdef FFT_REORDER_LAST_EN
            last_out  <= r_rd_vld && r_rd_idx == LAST;
`endif
        end
    end
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: randomized frame-level check of fft_reorder (N=3) against a reference model.
module tb_fft_reorder;
    localparam int W = 16;
    localparam int N = 3;

    typedef struct {int c; int re; int im;} smp_t;

    logic                clk = 1'b0;
    logic                areset = 1'b0;
    logic                en_in = 1'b0;
    logic [N-1:0]        cnt_in = '0;
    logic signed [W-1:0] xin_re = '0;
    logic signed [W-1:0] xin_im = '0;
    logic                en_out;
    logic [N-1:0]        cnt_out;
    logic signed [W-1:0] yout_re;
    logic signed [W-1:0] yout_im;
    logic                ovf;
`ifdef FFT_REORDER_LAST_EN
    logic                last_out;
`endif

    fft_reorder #(.width(W), .N(N)) dut (
        .clk(clk), .areset(areset), .en_in(en_in), .cnt_in(cnt_in),
        .xin_re(xin_re), .xin_im(xin_im), .en_out(en_out), .cnt_out(cnt_out),
        .yout_re(yout_re), .yout_im(yout_im), .ovf(ovf)
`ifdef FFT_REORDER_LAST_EN
        , .last_out(last_out)
`endif
    );

    always #5 clk = ~clk;

    int   total = 0, bad = 0;
    int   edges = 0, t_last = 0, en_cnt = 0, first_en = 0, last_en = 0;
    bit   lat_arm = 0, prev_en = 0, dropping = 0, exp_ovf = 0;
    int   wb = 0;
    int   mre[2][8], mim[2][8];
    smp_t q[$];
    smp_t e;

    always @(posedge clk) edges++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rev(input int c);
        return (c % 2) * 4 + ((c / 2) % 2) * 2 + c / 4;
    endfunction

    // Behavioural model: two frame buffers indexed in natural order; an accepted
    // frame end queues the whole buffer for output in natural order.
    task automatic put(input int c, input int re, input int im, input int gap);
        en_in = 1'b1; cnt_in = 3'(c); xin_re = 16'(re); xin_im = 16'(im);
        @(posedge clk); #1;
        en_in = 1'b0;
        if (!dropping) begin
            mre[wb][rev(c)] = re;
            mim[wb][rev(c)] = im;
        end
        if (c == 7) begin
            t_last = edges;
            if (dropping) exp_ovf = 1;
            else begin
                for (int k = 0; k < 8; k++) q.push_back('{k, mre[wb][k], mim[wb][k]});
                wb ^= 1;
            end
        end
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input bit dir, input bit shuf, input int gmin, input int gmax);
        int ord[8];
        for (int i = 0; i < 8; i++) ord[i] = i;
        if (shuf) for (int i = 1; i < 7; i++) begin
            int j = $urandom_range(6, 1);
            int t = ord[i];
            ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < 8; i++)
            put(ord[i], dir ? 10 * ord[i] : int'($urandom_range(65535)) - 32768,
                dir ? -ord[i] : int'($urandom_range(65535)) - 32768, $urandom_range(gmax, gmin));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin @(posedge clk); n++; end
        repeat (4) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
        chk("ovf", ovf, exp_ovf);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, en_out, 0);
        chk({tag, "_cnt"}, cnt_out, 0);
        chk({tag, "_re"}, yout_re, 0);
        chk({tag, "_im"}, yout_im, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        areset = 1'b0;
        q.delete(); wb = 0; exp_ovf = 0; en_cnt = 0; prev_en = 0;
        @(negedge clk);
        areset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (areset) begin
            if (en_out) begin
                en_cnt++;
                if (en_cnt == 1) first_en = edges;
                last_en = edges;
                chk("spurious", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("cnt_out", cnt_out, e.c);
                    chk("yout_re", $signed(yout_re), e.re);
                    chk("yout_im", $signed(yout_im), e.im);
                    if (e.c != 0) chk("contig", prev_en, 1);
                end
                if (lat_arm && cnt_out == 0) begin
                    chk("latency", edges - t_last, 3);
                    lat_arm = 0;
                end
            end
`ifdef FFT_REORDER_LAST_EN
            chk("last_out", last_out, en_out && cnt_out == 3'd7);
`endif
            prev_en = en_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        areset = 1'b1;

        lat_arm = 1;
        frame(1, 0, 0, 0);
        drain();
        chk("lat_seen", lat_arm, 0);

        en_cnt = 0;
        repeat (4) frame(0, 0, 0, 0);
        drain();
        chk("gapless_cnt", en_cnt, 32);
        chk("gapless_span", last_en - first_en + 1, 32);

        repeat (2) frame(0, 0, 1, 1);
        drain();

        repeat (6) frame(0, 1, 0, 3);
        drain();

        frame(0, 1, 0, 0);
        n = 0;
        while (!(en_out && cnt_out == 3'd4) && n < 100) begin @(negedge clk); n++; end
        chk("mid_found", 32'(n < 100), 1);
        #2;
        areset = 1'b0;
        q.delete(); wb = 0; en_cnt = 0;
        #1;
        chk_zero("mid_rst");
        @(posedge clk); #1;
        areset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("quiet", en_cnt, 0);
        frame(0, 0, 0, 1);
        drain();

        rst_pulse();
        frame(0, 0, 0, 0);
        drain();
        frame(0, 0, 0, 0);
        drain();
        frame(0, 0, 0, 0);
        put(0, 111, -111, 0);
        put(7, 777, -777, 0);
        dropping = 1;
        frame(0, 1, 0, 0);
        dropping = 0;
        #1;
        chk("ovf_set", ovf, 1);
        drain();
        frame(0, 1, 0, 2);
        drain();
        chk("ovf_sticky", ovf, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_reorder.md
Name: fft_reorder

Overview:
Output reorder unit at the tail of the radix-2 pipelined FFT chain.
- Consumes the last stage's bit-reversed output stream (en, cnt, re/im) and re-emits each frame in natural order, using the same en/cnt/data streaming interface.
- Uses a ping-pong RAM so that a full frame can be written while the previous frame is read out, which sustains continuous throughput.

Parameters:
- width, 16, sample width (signed, per re/im).
- N, 9, log2 of frame length; frame = 2^N samples.

Ports:
- clk  input  1  clock
- areset  input  1  asynchronous, active-low reset
- en_in  input  1  input sample valid
- cnt_in  input  N  bit-reversed-order sample index from last FFT stage
- xin_re  input  width  input real part (signed)
- xin_im  input  width  input imaginary part (signed)
- en_out  output  1  output sample valid
- cnt_out  output  N  natural-order output index
- yout_re  output  width  output real part (signed)
- yout_im  output  width  output imaginary part (signed)
- ovf  output  1  sticky overflow: a frame was dropped

Behaviour:
- Reset (areset low, async): en_out=0, cnt_out=0, yout_re=0, yout_im=0, ovf=0. Also bank_full=2'b00, wr_bank=0, rd_bank=0, drop=0, FSM=IDLE. Reset mid-frame discards all buffered data. No output resumes until a complete new frame is written.
- Storage: 2 banks x 2^N entries x 2*width bits. Reads are synchronous with 1-cycle latency. Single write port and single read port.
- Write side:
  - On a clk edge with en_in=1, write {xin_re,xin_im} to bank wr_bank at address bitrev_N(cnt_in), unless drop=1.
  - Frame start is en_in=1 with cnt_in=0. At frame start, drop is set if bank_full[wr_bank]=1, otherwise drop is cleared.
  - Exception: the bank counts as free if the reader is in READ on that same bank with rd_cnt=2^N-1 in that cycle.
  - Frame end is en_in=1 with cnt_in=2^N-1:
    - if drop=0: set bank_full[wr_bank] and toggle wr_bank;
    - if drop=1: set ovf and clear drop; wr_bank is unchanged.
  - Gaps in en_in are allowed. The write address always comes from cnt_in.
- Read FSM:
  - IDLE: if bank_full[rd_bank]=1, go to READ with rd_cnt=0.
  - READ: issue read at rd_cnt and increment rd_cnt each cycle. At rd_cnt=2^N-1:
    - clear bank_full[rd_bank], toggle rd_bank, rd_cnt wraps to 0;
    - stay in READ if bank_full of the other bank is set (or is being set this same edge); otherwise go to IDLE.
- Output register:
  - One cycle after the RAM read, en_out=1, cnt_out=issued rd_cnt, yout=RAM data.
  - Otherwise en_out=0; cnt_out and yout hold their last value.
- Latency: if the last sample of a frame is captured at edge T, then en_out=1 with cnt_out=0 appears after edge T+3. The frame is then emitted as exactly 2^N consecutive valid cycles with cnt_out 0..2^N-1.
- Back-to-back frames with en_in held continuously high produce a gapless en_out with no drops.
- Simultaneous events: a write and a read on the same bank never target the same address in the same cycle under the rules above. A bank_full set and clear on different banks in the same edge both take effect.
- ovf clears only on reset.

Optional Feature:
FFT_REORDER_LAST_EN:
- When defined, adds output port last_out (1 bit).
  - last_out=1 exactly when en_out=1 and cnt_out=2^N-1.
  - Registered together with en_out; reset value 0.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=3, reset then one frame: en_in=1 for 8 cycles, cnt_in=0..7, xin_re=10*cnt_in, xin_im=-cnt_in -> 3 cycles after the last input, en_out=1 for 8 cycles. cnt_out=0..7; yout_re at cnt_out=k is 10*bitrev3(k), e.g. cnt_out=1 gives 40 and cnt_out=3 gives 60.
- N=3, 4 continuous frames -> en_out high for 32 consecutive cycles, ovf=0, and each frame is reordered correctly.
- N=3, input with en_in gaps (valid every other cycle) -> same natural-order output per frame, with en_out contiguous for 8 cycles.
- N=3, frame 1 written, then areset pulsed low for 1 cycle mid-readout at cnt_out=4 -> all outputs 0 immediately; no further en_out until a new complete frame.
- N=3, cnt_in sequence forced so that three frames complete while the reader is blocked (two frames back-to-back with no gap; ovf check via third frame into a full bank) -> third frame dropped, ovf=1 and sticky, and the first two frames are output intact.
- With FFT_REORDER_LAST_EN defined, N=3 single frame -> last_out=1 only on the cycle cnt_out=7; otherwise 0.
